// File: rtl/viterbi_pkg.sv
// Shared types and constants for the 4-state (K=3) Viterbi decoder survivor/traceback path.
package viterbi_pkg;

  localparam logic [1:0] ST_00 = 2'b00;
  localparam logic [1:0] ST_01 = 2'b01;
  localparam logic [1:0] ST_10 = 2'b10;
  localparam logic [1:0] ST_11 = 2'b11;

  localparam int FRAME_LEN_DEF = 8;

  typedef enum logic [1:0] {
    TB_WRITE    = 2'b00,
    TB_WAIT_SEL = 2'b01,
    TB_TRACE    = 2'b10
  } tb_state_e;

  // One trellis step of survivors; element [s] is the predecessor of state s.
  typedef logic [3:0][1:0] sv_vec_t;

endpackage

// File: rtl/viterbi_sv_mem.sv
// Survivor-path register file: FRAME_LEN survivor vectors, synchronous write, combinational read.
import viterbi_pkg::*;

module viterbi_sv_mem #(
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int PTR_W     = $clog2(FRAME_LEN)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  sv_vec_t          wdata,
  input  logic [PTR_W-1:0] raddr,
  output sv_vec_t          rdata
);

  sv_vec_t mem_r [FRAME_LEN];

  // Survivor storage write port; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/viterbi_traceback.sv
// Survivor memory plus traceback FSM: stores a frame of ACS decisions, then walks back
// from the selected end state one step per cycle and emits the frame in forward bit order.
import viterbi_pkg::*;

module viterbi_traceback #(
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int PTR_W     = $clog2(FRAME_LEN)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sv_valid,
  input  logic [1:0]           prv_st_00,
  input  logic [1:0]           prv_st_01,
  input  logic [1:0]           prv_st_10,
  input  logic [1:0]           prv_st_11,
  input  logic                 sel_valid,
  input  logic [1:0]           sel_node,
  output logic                 sv_ready,
  output logic                 dec_valid,
  output logic [FRAME_LEN-1:0] dec_data,
  output logic                 overrun
);

  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(FRAME_LEN - 1);
  localparam logic [PTR_W-1:0] ZERO_IDX = {PTR_W{1'b0}};

  tb_state_e            state_r;
  logic [PTR_W-1:0]     wr_idx_r;
  logic [PTR_W-1:0]     rd_idx_r;
  logic [1:0]           cur_st_r;
  logic [FRAME_LEN-1:0] dec_data_r;
  logic                 dec_valid_r;
  logic                 overrun_r;
  logic                 sv_ready_r;
  logic                 we_s;
  sv_vec_t              wr_vec_s;
  sv_vec_t              rd_vec_s;

  // sv_ready_r is high exactly in TB_WRITE, so it doubles as the write qualifier.
  assign we_s     = sv_valid & sv_ready_r;
  assign wr_vec_s = {prv_st_11, prv_st_10, prv_st_01, prv_st_00};

  viterbi_sv_mem #(
    .FRAME_LEN (FRAME_LEN),
    .PTR_W     (PTR_W)
  ) u_sv_mem (
    .clk   (clk),
    .we    (we_s),
    .waddr (wr_idx_r),
    .wdata (wr_vec_s),
    .raddr (rd_idx_r),
    .rdata (rd_vec_s)
  );

  // Frame write / select wait / traceback sequencer with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= TB_WRITE;
      wr_idx_r    <= ZERO_IDX;
      rd_idx_r    <= ZERO_IDX;
      cur_st_r    <= ST_00;
      dec_data_r  <= {FRAME_LEN{1'b0}};
      dec_valid_r <= 1'b0;
      overrun_r   <= 1'b0;
      sv_ready_r  <= 1'b1;
    end else begin
      dec_valid_r <= 1'b0;
      if (sv_valid && !sv_ready_r) begin
        overrun_r <= 1'b1;
      end
      case (state_r)
        TB_WRITE: begin
          if (sv_valid) begin
            if (wr_idx_r == LAST_IDX) begin
              wr_idx_r   <= ZERO_IDX;
              state_r    <= TB_WAIT_SEL;
              sv_ready_r <= 1'b0;
            end else begin
              wr_idx_r <= wr_idx_r + PTR_W'(1);
            end
          end
        end
        TB_WAIT_SEL: begin
          if (sel_valid) begin
            cur_st_r <= sel_node;
            rd_idx_r <= LAST_IDX;
            state_r  <= TB_TRACE;
          end
        end
        TB_TRACE: begin
          // The bit for step i is the MSB of the state reached at step i.
          dec_data_r[rd_idx_r] <= cur_st_r[1];
          cur_st_r             <= rd_vec_s[cur_st_r];
          if (rd_idx_r == ZERO_IDX) begin
            dec_valid_r <= 1'b1;
            state_r     <= TB_WRITE;
            sv_ready_r  <= 1'b1;
          end else begin
            rd_idx_r <= rd_idx_r - PTR_W'(1);
          end
        end
        default: begin
          state_r    <= TB_WRITE;
          sv_ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign sv_ready  = sv_ready_r;
  assign dec_valid = dec_valid_r;
  assign dec_data  = dec_data_r;
  assign overrun   = overrun_r;

endmodule
